// File: rtl/mdc_output_reorder_pkg.sv
// Shared FFT constants and helpers for the 32-point MDC output reorder.
// Provides sizes, the bank address type and 4-bit bit reversal.
package mdc_output_reorder_pkg;

  localparam int N_FFT  = 32;
  localparam int HALF   = 16;
  localparam int ADDR_W = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  function automatic addr_t rev4(input addr_t a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

endpackage

// File: rtl/mdc_output_reorder_if.sv
// Handshake and data bundle between FFT last stage, reorder buffer and sink.
// slave: the reorder buffer side; master: the driving/consuming side.
interface mdc_output_reorder_if #(
  parameter int WIDTH = 9
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_first;
  logic signed [WIDTH-1:0] inU_re;
  logic signed [WIDTH-1:0] inU_im;
  logic signed [WIDTH-1:0] inL_re;
  logic signed [WIDTH-1:0] inL_im;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic signed [WIDTH-1:0] Up_out_re;
  logic signed [WIDTH-1:0] Up_out_im;
  logic signed [WIDTH-1:0] Low_out_re;
  logic signed [WIDTH-1:0] Low_out_im;
  logic                    frame_err;

  modport slave (
    input  in_valid, in_first,
    input  inU_re, inU_im, inL_re, inL_im,
    input  out_ready,
    output in_ready, out_valid, out_last,
    output Up_out_re, Up_out_im,
    output Low_out_re, Low_out_im,
    output frame_err
  );

  modport master (
    output in_valid, in_first,
    output inU_re, inU_im, inL_re, inL_im,
    output out_ready,
    input  in_ready, out_valid, out_last,
    input  Up_out_re, Up_out_im,
    input  Low_out_re, Low_out_im,
    input  frame_err
  );
endinterface

// File: rtl/mdc_reorder_bank.sv
// 16-entry flop bank holding {U_re,U_im,L_re,L_im} per entry.
// Ports: clk, i_we/i_waddr/i_wdata write, i_raddr -> o_rdata comb read.
module mdc_reorder_bank
  import mdc_output_reorder_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic               clk,
  input  logic               i_we,
  input  addr_t              i_waddr,
  input  logic [4*WIDTH-1:0] i_wdata,
  input  addr_t              i_raddr,
  output logic [4*WIDTH-1:0] o_rdata
);

  logic [4*WIDTH-1:0] r_mem [HALF];

  // Contents are don't-care after reset; full flags gate all reads.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mdc_output_reorder.sv
// Ping-pong reorder: bit-reversed U/L pair stream in, natural order out.
// Ports: clk, rst_n (async low), bus (slave) with in_/out_ handshakes.
module mdc_output_reorder
  import mdc_output_reorder_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mdc_output_reorder_if.slave  bus
);

  localparam addr_t LAST = addr_t'(HALF - 1);

  addr_t              r_wcnt;
  addr_t              r_rcnt;
  logic               r_wbank;
  logic               r_rbank;
  logic [1:0]         r_full;
  logic               r_frame_err;

  logic               w_in_rdy;
  logic               w_acc;
  logic               w_resync;
  logic               w_wdone;
  logic               w_ovld;
  logic               w_rd;
  logic               w_rdone;
  addr_t              w_waddr;
  logic [1:0]         w_we;
  logic [1:0]         w_full_nxt;
  logic [4*WIDTH-1:0] w_wdata;
  logic [4*WIDTH-1:0] w_rd0;
  logic [4*WIDTH-1:0] w_rd1;
  logic [4*WIDTH-1:0] w_rdata;
  logic [4*WIDTH-1:0] w_odata;

  assign w_in_rdy = ~r_full[r_wbank];
  assign w_acc    = bus.in_valid & w_in_rdy;
  // A frame start mid-frame drops the partial frame and restarts at c=0.
  assign w_resync = w_acc & bus.in_first & (r_wcnt != '0);
  assign w_wdone  = w_acc & ~w_resync & (r_wcnt == LAST);
  assign w_waddr  = w_resync ? '0 : rev4(r_wcnt);
  assign w_wdata  = {bus.inU_re, bus.inU_im,
                     bus.inL_re, bus.inL_im};
  assign w_we[0]  = w_acc & ~r_wbank;
  assign w_we[1]  = w_acc &  r_wbank;

  assign w_ovld   = r_full[r_rbank];
  assign w_rd     = w_ovld & bus.out_ready;
  assign w_rdone  = w_rd & (r_rcnt == LAST);

  // Writer and reader always target different banks when both fire.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wdone) w_full_nxt[r_wbank] = 1'b1;
    if (w_rdone) w_full_nxt[r_rbank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_wbank     <= 1'b0;
      r_rbank     <= 1'b0;
      r_full      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_resync) begin
        r_wcnt      <= addr_t'(1);
        r_frame_err <= 1'b1;
      end else if (w_acc) begin
        r_wcnt <= r_wcnt + addr_t'(1);
      end
      if (w_wdone) r_wbank <= ~r_wbank;
      if (w_rd)    r_rcnt  <= r_rcnt + addr_t'(1);
      if (w_rdone) r_rbank <= ~r_rbank;
    end
  end

  mdc_reorder_bank #(.WIDTH(WIDTH)) u_bank0 (
    .clk     (clk),
    .i_we    (w_we[0]),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_rcnt),
    .o_rdata (w_rd0)
  );

  mdc_reorder_bank #(.WIDTH(WIDTH)) u_bank1 (
    .clk     (clk),
    .i_we    (w_we[1]),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_rcnt),
    .o_rdata (w_rd1)
  );

  assign w_rdata = r_rbank ? w_rd1 : w_rd0;
  assign w_odata = w_ovld ? w_rdata : '0;

  assign bus.in_ready   = w_in_rdy;
  assign bus.out_valid  = w_ovld;
  assign bus.out_last   = w_ovld & (r_rcnt == LAST);
  assign bus.frame_err  = r_frame_err;
  assign bus.Up_out_re  = w_odata[4*WIDTH-1:3*WIDTH];
  assign bus.Up_out_im  = w_odata[3*WIDTH-1:2*WIDTH];
  assign bus.Low_out_re = w_odata[2*WIDTH-1:WIDTH];
  assign bus.Low_out_im = w_odata[WIDTH-1:0];

endmodule

// File: doc/mdc_output_reorder.md
Name: mdc_output_reorder

Overview:
- Output-side reorder buffer for the 32-point MDC FFT. It is the reader of the frames that the last-stage commutator and butterfly write.
- Accepts the two parallel output streams (upper/lower) in bit-reversed order.
- Emits them as two natural-order streams: upper carries bins 0..15, lower carries bins 16..31, one pair per cycle.
- Ping-pong storage with valid/ready handshakes on both sides sustains one frame per 16 cycles.

Parameters:
- WIDTH, 9, signed bit width of each re/im component (matches FFT datapath width).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input pair valid.
- in_ready, output, 1, buffer can accept a pair this cycle.
- in_first, input, 1, marks the first pair (cycle 0) of a frame.
- inU_re, input, WIDTH, upper stream real part (signed).
- inU_im, input, WIDTH, upper stream imaginary part (signed).
- inL_re, input, WIDTH, lower stream real part (signed).
- inL_im, input, WIDTH, lower stream imaginary part (signed).
- out_valid, output, 1, output pair valid.
- out_ready, input, 1, downstream accepts the pair.
- out_last, output, 1, high with the 16th pair of a frame.
- Up_out_re, output, WIDTH, natural-order bin k, real part, k = 0..15.
- Up_out_im, output, WIDTH, natural-order bin k, imaginary part.
- Low_out_re, output, WIDTH, natural-order bin k+16, real part.
- Low_out_im, output, WIDTH, natural-order bin k+16, imaginary part.
- frame_err, output, 1, sticky: a frame was restarted before completing.

Behaviour:
- Input ordering: the c-th accepted pair of a frame (c = 0..15) carries upper = bin rev4(c) and lower = bin 16+rev4(c), where rev4 is 4-bit bit reversal.
- Storage: two banks (0/1). Each bank holds 16 entries × {U_re, U_im, L_re, L_im}, flop-based, with a full flag per bank.
- Write side:
  - Accept a pair when in_valid & in_ready.
  - Write counter wcnt (4 bits); entry address = rev4(wcnt) in bank wbank.
  - On the accept with wcnt==15: set full[wbank], toggle wbank, wcnt wraps to 0.
  - in_ready = ~full[wbank] (registered state only, no combinational path from out_ready).
- Frame resync: an accept with in_first=1 while wcnt!=0 discards the partial frame. The pair is written at address 0 as c=0, wcnt becomes 1, and frame_err is set. frame_err is cleared only by reset.
- An accept with in_first=0 while wcnt==0 is accepted normally (no error).
- Read side:
  - out_valid = full[rbank].
  - Output data = entry rcnt of bank rbank, combinational from storage.
  - All four data outputs are forced to 0 when out_valid=0.
  - out_last = out_valid & (rcnt==15).
  - On out_valid & out_ready: rcnt++. At rcnt==15, clear full[rbank], toggle rbank, rcnt wraps to 0.
- Latency: the first output pair is valid the cycle after the 16th input pair is accepted.
- Throughput: with in_valid and out_ready held at 1, in_ready never drops and output is continuous, one frame per 16 cycles.
- Simultaneous events:
  - Setting full on one bank and clearing full on the other in the same cycle are both applied.
  - The same bank can never be set and cleared in the same cycle, because writes only target non-full banks.
- Back-pressure: when both banks are full, in_ready=0. in_ready returns the cycle after the final pair of the read bank is accepted.
- Reset (asynchronous, including mid-frame):
  - wcnt = rcnt = 0, wbank = rbank = 0, both full flags = 0, frame_err = 0.
  - out_valid = 0, out_last = 0, data outputs = 0, in_ready = 1 after reset.
  - Storage contents need not be reset. Partial frames are lost.

Decomposition:
- Shared FFT package: constant N_FFT=32, HALF=16, ADDR_W=4, and a rev4 bit-reverse function.
- Sub-module: mdc_reorder_bank, one 16-entry 4-component register bank with write enable/address and combinational read address. Instantiate it twice.

Test Plan:
- Single frame: feed c=0..15 with U_re=rev4(c), L_re=16+rev4(c) (im = -U_re, -L_re), out_ready=1. Expected outputs on cycles 17..32: Up_out_re=k, Low_out_re=16+k for k=0..15, out_last on k=15, frame_err=0.
- Back-to-back: 4 frames, in_valid=1 continuously. Expected: in_ready stays 1 throughout, 64 consecutive out_valid cycles, correct natural order per frame.
- Back-pressure: out_ready=0 for 40 cycles while feeding. Expected: in_ready drops after 32 accepts; no data loss; order correct after out_ready=1; in_ready rises the cycle after the 16th read of bank 0.
- Resync: in_first at c=0, then again after 7 pairs. Expected: frame_err=1; the frame that follows outputs exactly the 16 pairs after the second in_first.
- Reset mid-frame: assert rst_n=0 after 10 input pairs and 5 output pairs. Expected: out_valid=0 and data=0 immediately (asynchronous); after release in_ready=1; a fresh frame reorders correctly.
- Signed extremes: U_re=-256, L_im=+255 at c=5. Expected: Up_out_re=-256 at k=10, Low_out_im=+255 at k=10, passed through unchanged.
